wb_port_arbiter: RTL
====================

WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 The module SHALL have parameter DATA_W, default 32: write-data width.
REQ-002 The module SHALL have parameter ADDR_W, default 5: register-address width.
REQ-003 The module SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 The module SHALL have port req, input, 4: per-requester write request; held until granted.
REQ-006 The module SHALL have port req_data, input, 4*DATA_W: requester i data at [i*DATA_W +: DATA_W].
REQ-007 The module SHALL have port req_addr, input, 4*ADDR_W: requester i address at [i*ADDR_W +: ADDR_W].
REQ-008 The module SHALL have port gnt, output, 4: one-hot combinational grant; gnt[i]=1 means requester i is captured at this edge.
REQ-009 The module SHALL have port wr_valid, output, 1: registered register-file write strobe.
REQ-010 The module SHALL have port wr_addr, output, ADDR_W: registered write address.
REQ-011 The module SHALL have port wr_data, output, DATA_W: registered write data.
REQ-012 The module SHALL have port wr_src, output, 2: index of the requester that owns the current wr_* beat; this is the encoded select of the 4:1 datapath mux.
REQ-013 The module SHALL have port wr_ready, input, 1: sink accepts the wr_* beat when wr_valid and wr_ready are both 1.

Function
REQ-014 The module SHALL define slot_free = !wr_valid || wr_ready.
REQ-015 The module SHALL assert at most one gnt bit per cycle, and only when slot_free=1 and that req bit is 1.
REQ-016 The module SHALL drive gnt=0 when slot_free=0, whatever req is.
REQ-017 On a grant to i, the module SHALL load wr_data, wr_addr and wr_src from requester i at the same edge: latency req->wr_valid is 1 cycle.
REQ-018 A granted beat whose address is 0 (the $zero register) SHALL be consumed (gnt pulses) without setting wr_valid; wr_valid SHALL clear at that edge if the slot drained.
REQ-019 When wr_valid=1, wr_ready=1 and no grant occurs, the module SHALL clear wr_valid at the edge.
REQ-020 When wr_valid=1 and wr_ready=0, the module SHALL hold wr_valid, wr_addr, wr_data and wr_src stable.
REQ-021 Drain and a new grant in the same cycle SHALL give a back-to-back beat, with wr_valid staying 1 and no bubble.
REQ-022 The module SHALL keep a 2-bit priority pointer ptr; the search order SHALL be ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-023 After a grant to i, ptr SHALL become (i+1) mod 4 (wrap 3->0); ptr SHALL be unchanged in cycles without a grant.
REQ-024 Requests deasserted before being granted SHALL be dropped silently with no state change.

Reset
REQ-025 While rst_n=0, the module SHALL force wr_valid=0, wr_addr=0, wr_data=0, wr_src=0 and ptr=0, independent of clk.
REQ-026 While rst_n=0, gnt SHALL be 0.
REQ-027 Assertion of rst_n mid-operation SHALL discard any pending beat; the first grant after release SHALL search from requester 0.

Configuration
REQ-028 With macro WB_ARB_ROUND_ROBIN_EN defined, the module SHALL arbitrate round-robin per REQ-022/023.
REQ-029 With WB_ARB_ROUND_ROBIN_EN undefined, the module SHALL use fixed priority req[0]>req[1]>req[2]>req[3], and ptr SHALL not exist or SHALL remain 0.

Verification
REQ-030 Reset, then req=0001, addr=3, data=0xDEADBEEF, wr_ready=1 -> gnt=0001 in cycle 0; cycle 1: wr_valid=1, wr_addr=3, wr_data=0xDEADBEEF, wr_src=0.
REQ-031 req=1111 held, all addrs nonzero, wr_ready=1 (RR build) -> grants 0,1,2,3,0 on consecutive cycles with continuous wr_valid; fixed-prio build -> grant 0 every cycle.
REQ-032 wr_valid=1, wr_ready=0 for 3 cycles with req=0100 -> gnt=0 and wr_* stable for those 3 cycles; on wr_ready=1, gnt=0100 in the same cycle, new beat next cycle.
REQ-033 req=0010 with addr=0 -> gnt=0010 pulses; wr_valid stays 0 the following cycle; ptr advances to 2 (RR build).
REQ-034 Last grant to requester 3, then req=1001 -> grant goes to 0 (wrap); rst_n pulsed low while wr_valid=1 -> wr_valid=0 immediately, with no clk edge.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Four-port write arbiter feeding one registered register-file write port.
// Define WB_ARB_ROUND_ROBIN_EN for round-robin; default is fixed priority 0>1>2>3.
module wb_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [3:0]            req,
    input  logic [4*DATA_W-1:0]   req_data,
    input  logic [4*ADDR_W-1:0]   req_addr,
    output logic [3:0]            gnt,
    output logic                  wr_valid,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    output logic [1:0]            wr_src,
    input  logic                  wr_ready
);

    logic              wr_valid_q, wr_valid_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [1:0]        wr_src_q, wr_src_d;

    logic              slot_free;
    logic              hit;
    logic              grant;
    logic [1:0]        sel;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] idx;

    // Walk from the farthest offset inward so the slot nearest ptr wins.
    always_comb begin
        hit = 1'b0;
        sel = 2'd0;
        idx = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            idx = ptr_q + 2'(k);
            if (req[idx]) begin
                hit = 1'b1;
                sel = idx;
            end
        end
    end
`else
    always_comb begin
        hit = 1'b0;
        sel = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req[k]) begin
                hit = 1'b1;
                sel = 2'(k);
            end
        end
    end
`endif

    assign slot_free = !wr_valid_q || wr_ready;
    assign grant     = hit && slot_free && rst_n;
    assign gnt       = grant ? (4'b0001 << sel) : 4'b0000;
    assign sel_addr  = req_addr[int'(sel)*ADDR_W +: ADDR_W];
    assign sel_data  = req_data[int'(sel)*DATA_W +: DATA_W];

    // A beat to the $zero register is consumed but never presented.
    always_comb begin
        wr_valid_d = wr_valid_q;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        wr_src_d   = wr_src_q;
        if (wr_valid_q && wr_ready) begin
            wr_valid_d = 1'b0;
        end
        if (grant) begin
            wr_valid_d = (sel_addr != '0);
            wr_addr_d  = sel_addr;
            wr_data_d  = sel_data;
            wr_src_d   = sel;
        end
    end

`ifdef WB_ARB_ROUND_ROBIN_EN
    always_comb begin
        ptr_d = ptr_q;
        if (grant) begin
            ptr_d = sel + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 2'd0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_src_q   <= 2'd0;
        end else begin
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            wr_src_q   <= wr_src_d;
        end
    end

    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign wr_src   = wr_src_q;

endmodule
